rx8b10b_dec: RTL and testbench

Registered 8b/10b decoder on the receive path, directly downstream of the 10-bit comma aligner. It consumes aligned 10-bit code groups and tracks running disparity (RD). It returns zero-latency not-in-table and disparity-error flags to the aligner's sync state machine, and emits registered byte/K/comma outputs to the PCS. It also keeps saturating error counters for debug.

---
 rtl/rx8b10b_pkg.sv | 36 +++
 rtl/rx8b10b_lut.sv | 112 +++++++++++
 rtl/rx8b10b_dec.sv | 106 ++++++++++
 tb/tb_rx8b10b_dec.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/rx8b10b_pkg.sv
// Shared constants and helpers for the 8b/10b receive decoder: K28.5 comma
// forms, running-disparity encoding and sub-block disparity classes.
package rx8b10b_pkg;

  localparam logic [9:0] K28_5_RDN = 10'h17C;
  localparam logic [9:0] K28_5_RDP = 10'h283;

  localparam logic RD_NEG = 1'b0;
  localparam logic RD_POS = 1'b1;

  typedef enum logic [2:0] {
    DISP_NEUTRAL   = 3'd0,
    DISP_POS2      = 3'd1,
    DISP_NEG2      = 3'd2,
    DISP_FORCE_POS = 3'd3,
    DISP_FORCE_NEG = 3'd4
  } disp_class_e;

  function automatic logic rd_after(input disp_class_e cls, input logic rd);
    case (cls)
      DISP_POS2, DISP_FORCE_POS: return RD_POS;
      DISP_NEG2, DISP_FORCE_NEG: return RD_NEG;
      default:                   return rd;
    endcase
  endfunction

  // 000111 / 0011 are only transmitted from RD+ and 111000 / 1100 from RD-,
  // so a forcing block is wrong when it arrives on the opposite RD.
  function automatic logic disp_err(input disp_class_e cls, input logic rd);
    return ((cls == DISP_POS2)      && (rd == RD_POS)) ||
           ((cls == DISP_NEG2)      && (rd == RD_NEG)) ||
           ((cls == DISP_FORCE_POS) && (rd == RD_NEG)) ||
           ((cls == DISP_FORCE_NEG) && (rd == RD_POS));
  endfunction

endpackage

// File: rtl/rx8b10b_lut.sv
// Combinational 6b/5b and 4b/3b lookup: decoded bits, K flag, code validity
// and the disparity class of each sub-block.
module rx8b10b_lut
  import rx8b10b_pkg::*;
(
  input  logic [9:0]  code,
  output logic [4:0]  dec5,
  output logic [2:0]  dec3,
  output logic        is_k,
  output logic        valid,
  output disp_class_e disp6,
  output disp_class_e disp4
);

  logic [5:0] s6;   // {a,b,c,d,e,i}, a in the MSB
  logic [3:0] f4;   // {f,g,h,j}, f in the MSB
  logic [3:0] f4_eff;
  logic       ok6, k28, kable, a7, p7, d_a7, p7_bad;

  for (genvar gi = 0; gi < 6; gi++) begin : g_s6
    assign s6[5-gi] = code[gi];
  end
  for (genvar gi = 0; gi < 4; gi++) begin : g_f4
    assign f4[3-gi] = code[6+gi];
  end

  always_comb begin
    ok6  = 1'b1;
    dec5 = 5'd0;
    case (s6)
      6'b100111, 6'b011000: dec5 = 5'd0;
      6'b011101, 6'b100010: dec5 = 5'd1;
      6'b101101, 6'b010010: dec5 = 5'd2;
      6'b110001:            dec5 = 5'd3;
      6'b110101, 6'b001010: dec5 = 5'd4;
      6'b101001:            dec5 = 5'd5;
      6'b011001:            dec5 = 5'd6;
      6'b111000, 6'b000111: dec5 = 5'd7;
      6'b111001, 6'b000110: dec5 = 5'd8;
      6'b100101:            dec5 = 5'd9;
      6'b010101:            dec5 = 5'd10;
      6'b110100:            dec5 = 5'd11;
      6'b001101:            dec5 = 5'd12;
      6'b101100:            dec5 = 5'd13;
      6'b011100:            dec5 = 5'd14;
      6'b010111, 6'b101000: dec5 = 5'd15;
      6'b011011, 6'b100100: dec5 = 5'd16;
      6'b100011:            dec5 = 5'd17;
      6'b010011:            dec5 = 5'd18;
      6'b110010:            dec5 = 5'd19;
      6'b001011:            dec5 = 5'd20;
      6'b101010:            dec5 = 5'd21;
      6'b011010:            dec5 = 5'd22;
      6'b111010, 6'b000101: dec5 = 5'd23;
      6'b110011, 6'b001100: dec5 = 5'd24;
      6'b100110:            dec5 = 5'd25;
      6'b010110:            dec5 = 5'd26;
      6'b110110, 6'b001001: dec5 = 5'd27;
      6'b001110, 6'b001111, 6'b110000: dec5 = 5'd28;
      6'b101110, 6'b010001: dec5 = 5'd29;
      6'b011110, 6'b100001: dec5 = 5'd30;
      6'b101011, 6'b010100: dec5 = 5'd31;
      default:              ok6  = 1'b0;
    endcase

    // The RD+ form of K28 complements the whole 4b block, which swaps the
    // meaning of the alternating codes (x.1/x.6, x.2/x.5).
    f4_eff = (s6 == 6'b110000) ? ~f4 : f4;
    dec3   = 3'd0;
    case (f4_eff)
      4'b1011, 4'b0100:                   dec3 = 3'd0;
      4'b1001:                            dec3 = 3'd1;
      4'b0101:                            dec3 = 3'd2;
      4'b1100, 4'b0011:                   dec3 = 3'd3;
      4'b1101, 4'b0010:                   dec3 = 3'd4;
      4'b1010:                            dec3 = 3'd5;
      4'b0110:                            dec3 = 3'd6;
      4'b1110, 4'b0001, 4'b0111, 4'b1000: dec3 = 3'd7;
      default:                            dec3 = 3'd0;
    endcase

    k28   = (s6 == 6'b001111) || (s6 == 6'b110000);
    kable = (s6 == 6'b111010) || (s6 == 6'b000101) || (s6 == 6'b110110) ||
            (s6 == 6'b001001) || (s6 == 6'b101110) || (s6 == 6'b010001) ||
            (s6 == 6'b011110) || (s6 == 6'b100001);
    a7    = (f4 == 4'b0111) || (f4 == 4'b1000);
    p7    = (f4 == 4'b1110) || (f4 == 4'b0001);
    d_a7  = ((f4 == 4'b0111) && (s6 == 6'b100011 || s6 == 6'b010011 || s6 == 6'b001011)) ||
            ((f4 == 4'b1000) && (s6 == 6'b110100 || s6 == 6'b101100 || s6 == 6'b011100));
    // P7 after e=i would build a run of five; K28.7 only exists in A7 form.
    p7_bad = ((f4 == 4'b1110) && s6[1] && s6[0]) ||
             ((f4 == 4'b0001) && !s6[1] && !s6[0]) ||
             (k28 && p7);

    valid = ok6 && (f4 != 4'b0000) && (f4 != 4'b1111) && !p7_bad &&
            (!a7 || k28 || kable || d_a7);
    is_k  = k28 || (kable && a7);

    if (s6 == 6'b000111)       disp6 = DISP_FORCE_POS;
    else if (s6 == 6'b111000)  disp6 = DISP_FORCE_NEG;
    else if ($countones(s6) > 3) disp6 = DISP_POS2;
    else if ($countones(s6) < 3) disp6 = DISP_NEG2;
    else                       disp6 = DISP_NEUTRAL;

    if (f4 == 4'b0011)         disp4 = DISP_FORCE_POS;
    else if (f4 == 4'b1100)    disp4 = DISP_FORCE_NEG;
    else if ($countones(f4) > 2) disp4 = DISP_POS2;
    else if ($countones(f4) < 2) disp4 = DISP_NEG2;
    else                       disp4 = DISP_NEUTRAL;
  end

endmodule

// File: rtl/rx8b10b_dec.sv
// Registered 8b/10b receive decoder: running-disparity tracking, same-cycle
// error flags for the sync state machine, registered byte output, error counters.
module rx8b10b_dec
  import rx8b10b_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_RxDecEn,
  input  logic [9:0]       i_RxData,
  input  logic             i_RxSyncLock,
  input  logic             i_RxDispChkEn,
  input  logic             i_RxErrCntClr,
  output logic             o_RxNotInTable,
  output logic             o_RxDispErr,
  output logic [7:0]       o_RxData,
  output logic             o_RxIsK,
  output logic             o_RxIsComma,
  output logic             o_RxCodeErr,
  output logic             o_RxValid,
  output logic             o_RxRunDisp,
  output logic [CNT_W-1:0] o_RxNitCnt,
  output logic [CNT_W-1:0] o_RxDispErrCnt
);

  logic [4:0]  dec5;
  logic [2:0]  dec3;
  logic        lut_k, lut_valid;
  disp_class_e disp6, disp4;

  logic             rd_reg, rd6, rd_next, resync, nit, derr, comma;
  logic [7:0]       data_reg;
  logic             k_reg, comma_reg, cerr_reg, valid_reg;
  logic [CNT_W-1:0] nit_cnt_reg, derr_cnt_reg;

  rx8b10b_lut u_lut (
    .code  (i_RxData),
    .dec5  (dec5),
    .dec3  (dec3),
    .is_k  (lut_k),
    .valid (lut_valid),
    .disp6 (disp6),
    .disp4 (disp4)
  );

  always_comb begin
    rd6    = rd_after(disp6, rd_reg);
    resync = !i_RxSyncLock && ((i_RxData == K28_5_RDN) || (i_RxData == K28_5_RDP));
    // While hunting for sync, a K28.5 re-seeds RD instead of being judged by it.
    if (resync)
      rd_next = (i_RxData == K28_5_RDN) ? RD_POS : RD_NEG;
    else
      rd_next = rd_after(disp4, rd6);
    nit   = i_RxDecEn && !lut_valid;
    derr  = i_RxDecEn && i_RxDispChkEn && !resync &&
            (disp_err(disp6, rd_reg) || disp_err(disp4, rd6));
    comma = lut_valid && lut_k && (dec5 == 5'd28) &&
            ((dec3 == 3'd1) || (dec3 == 3'd5) || (dec3 == 3'd7));
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      rd_reg    <= RD_NEG;
      data_reg  <= '0;
      k_reg     <= 1'b0;
      comma_reg <= 1'b0;
      cerr_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else if (i_RxDecEn) begin
      rd_reg    <= rd_next;
      data_reg  <= {dec3, dec5};
      k_reg     <= lut_valid && lut_k;
      comma_reg <= comma;
      cerr_reg  <= nit || derr;
      valid_reg <= 1'b1;
    end else begin
      valid_reg <= 1'b0;
    end
  end

  // nit/derr already carry the enable, so only lock gates counting here.
  always_ff @(posedge i_Clk) begin
    if (i_Rst || i_RxErrCntClr) begin
      nit_cnt_reg  <= '0;
      derr_cnt_reg <= '0;
    end else if (i_RxSyncLock) begin
      if (nit && (nit_cnt_reg != '1))
        nit_cnt_reg <= nit_cnt_reg + CNT_W'(1);
      if (derr && (derr_cnt_reg != '1))
        derr_cnt_reg <= derr_cnt_reg + CNT_W'(1);
    end
  end

  assign o_RxNotInTable = nit;
  assign o_RxDispErr    = derr;
  assign o_RxData       = data_reg;
  assign o_RxIsK        = k_reg;
  assign o_RxIsComma    = comma_reg;
  assign o_RxCodeErr    = cerr_reg;
  assign o_RxValid      = valid_reg;
  assign o_RxRunDisp    = rd_reg;
  assign o_RxNitCnt     = nit_cnt_reg;
  assign o_RxDispErrCnt = derr_cnt_reg;

endmodule

// File: tb/tb_rx8b10b_dec.sv
// Directed vector bench for rx8b10b_dec: table of hand-decoded groups plus a
// counter saturation / clear sequence.
module tb_rx8b10b_dec;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic [9:0]       rx_data = '0;
  logic             lock = 1'b0;
  logic             chk = 1'b0;
  logic             clr = 1'b0;
  logic             nit_o, derr_o, k_o, comma_o, cerr_o, valid_o, rd_o;
  logic [7:0]       data_o;
  logic [CNT_W-1:0] nit_cnt_o, derr_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  rx8b10b_dec #(.CNT_W(CNT_W)) dut (
    .i_Clk          (clk),
    .i_Rst          (rst),
    .i_RxDecEn      (en),
    .i_RxData       (rx_data),
    .i_RxSyncLock   (lock),
    .i_RxDispChkEn  (chk),
    .i_RxErrCntClr  (clr),
    .o_RxNotInTable (nit_o),
    .o_RxDispErr    (derr_o),
    .o_RxData       (data_o),
    .o_RxIsK        (k_o),
    .o_RxIsComma    (comma_o),
    .o_RxCodeErr    (cerr_o),
    .o_RxValid      (valid_o),
    .o_RxRunDisp    (rd_o),
    .o_RxNitCnt     (nit_cnt_o),
    .o_RxDispErrCnt (derr_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rst, en, lock, chk, data;           // inputs
    int nit, derr;                          // same-cycle flags
    int cmp_dat, dat, k, comma, cerr, valid; // registered outputs
    int cmp_rd, rd, nc, dc;
  } vec_t;

  vec_t vecs [22];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic l, input logic c,
                       input logic cl, input logic [9:0] d);
    @(negedge clk);
    rst = r; en = e; lock = l; chk = c; clr = cl; rx_data = d;
  endtask

  initial begin
    //          rst en lk ck data    nit de  cd dat    k  cm ce va  cr rd nc dc
    vecs[0]  = '{1, 0, 0, 0, 'h000,  0, 0,  1, 'h00,  0, 0, 0, 0,  1, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 'h000,  0, 0,  1, 'h00,  0, 0, 0, 0,  1, 0, 0, 0};
    vecs[2]  = '{0, 1, 1, 1, 'h17C,  0, 0,  1, 'hBC,  1, 1, 0, 1,  1, 1, 0, 0};
    vecs[3]  = '{0, 1, 1, 1, 'h155,  0, 0,  1, 'hB5,  0, 0, 0, 1,  1, 1, 0, 0};
    vecs[4]  = '{0, 1, 1, 1, 'h283,  0, 0,  1, 'hBC,  1, 1, 0, 1,  1, 0, 0, 0};
    vecs[5]  = '{0, 1, 1, 1, 'h155,  0, 0,  1, 'hB5,  0, 0, 0, 1,  1, 0, 0, 0};
    vecs[6]  = '{0, 1, 1, 1, 'h283,  0, 1,  1, 'hBC,  1, 1, 1, 1,  1, 0, 0, 1};
    vecs[7]  = '{0, 1, 1, 1, 'h17C,  0, 0,  1, 'hBC,  1, 1, 0, 1,  1, 1, 0, 1};
    vecs[8]  = '{0, 1, 0, 1, 'h17C,  0, 0,  1, 'hBC,  1, 1, 0, 1,  1, 1, 0, 1};
    vecs[9]  = '{0, 1, 0, 1, 'h27C,  0, 1,  1, 'h3C,  1, 1, 1, 1,  1, 1, 0, 1};
    vecs[10] = '{0, 1, 1, 0, 'h000,  1, 0,  0, 'h00,  0, 0, 1, 1,  0, 0, 1, 1};
    vecs[11] = '{0, 1, 1, 0, 'h3FF,  1, 0,  0, 'h00,  0, 0, 1, 1,  0, 0, 2, 1};
    vecs[12] = '{1, 1, 1, 0, 'h283,  0, 0,  1, 'h00,  0, 0, 0, 0,  1, 0, 0, 0};
    vecs[13] = '{1, 1, 1, 0, 'h283,  0, 0,  1, 'h00,  0, 0, 0, 0,  1, 0, 0, 0};
    vecs[14] = '{0, 1, 1, 1, 'h283,  0, 1,  1, 'hBC,  1, 1, 1, 1,  1, 0, 0, 1};
    vecs[15] = '{0, 1, 1, 1, 'h17C,  0, 0,  1, 'hBC,  1, 1, 0, 1,  1, 1, 0, 1};
    vecs[16] = '{0, 0, 1, 1, 'h3FF,  0, 0,  1, 'hBC,  1, 1, 0, 0,  1, 1, 0, 1};
    vecs[17] = '{0, 1, 1, 1, 'h155,  0, 0,  1, 'hB5,  0, 0, 0, 1,  1, 1, 0, 1};
    vecs[18] = '{0, 1, 1, 1, 'h231,  0, 0,  1, 'hF1,  0, 0, 0, 1,  1, 0, 0, 1};
    vecs[19] = '{0, 1, 1, 1, 'h3B1,  0, 0,  1, 'hF1,  0, 0, 0, 1,  1, 1, 0, 1};
    vecs[20] = '{0, 1, 1, 1, 'h1F1,  1, 1,  0, 'h00,  0, 0, 1, 1,  1, 1, 1, 2};
    vecs[21] = '{0, 1, 1, 1, 'h3A8,  0, 0,  1, 'hF7,  1, 0, 0, 1,  1, 1, 1, 2};

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].rst[0], vecs[i].en[0], vecs[i].lock[0], vecs[i].chk[0], 1'b0,
            10'(vecs[i].data));
      #1;
      check($sformatf("v%0d not_in_table", i), int'(nit_o), vecs[i].nit);
      check($sformatf("v%0d disp_err", i), int'(derr_o), vecs[i].derr);
      @(posedge clk);
      #1;
      if (vecs[i].cmp_dat != 0) check($sformatf("v%0d data", i), int'(data_o), vecs[i].dat);
      check($sformatf("v%0d is_k", i), int'(k_o), vecs[i].k);
      check($sformatf("v%0d is_comma", i), int'(comma_o), vecs[i].comma);
      check($sformatf("v%0d code_err", i), int'(cerr_o), vecs[i].cerr);
      check($sformatf("v%0d valid", i), int'(valid_o), vecs[i].valid);
      if (vecs[i].cmp_rd != 0) check($sformatf("v%0d run_disp", i), int'(rd_o), vecs[i].rd);
      check($sformatf("v%0d nit_cnt", i), int'(nit_cnt_o), vecs[i].nc);
      check($sformatf("v%0d derr_cnt", i), int'(derr_cnt_o), vecs[i].dc);
      $display("vec %0d data=0x%03h -> byte=0x%02h k=%0b comma=%0b cerr=%0b valid=%0b rd=%0b cnt=%0d/%0d",
               i, vecs[i].data, data_o, k_o, comma_o, cerr_o, valid_o, rd_o, nit_cnt_o, derr_cnt_o);
    end

    // Clear together with an error: clear wins for both counters.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'h3FF);
    #1;
    check("clr_err not_in_table", int'(nit_o), 1);
    @(posedge clk);
    #1;
    check("clr_err nit_cnt", int'(nit_cnt_o), 0);
    check("clr_err derr_cnt", int'(derr_cnt_o), 0);
    $display("clear+error -> cnt=%0d/%0d", nit_cnt_o, derr_cnt_o);

    // Keep injecting past all-ones: the count must stick at the top.
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h3FF);
      @(posedge clk);
      #1;
      check($sformatf("sat%0d nit_cnt", i), int'(nit_cnt_o), (i + 1 > CMAX) ? CMAX : i + 1);
      $display("inject %0d -> nit_cnt=%0d", i, nit_cnt_o);
    end

    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'h3FF);
    @(posedge clk);
    #1;
    check("sat_clr nit_cnt", int'(nit_cnt_o), 0);
    $display("clear at saturation -> nit_cnt=%0d", nit_cnt_o);

    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h3FF);
    @(posedge clk);
    #1;
    check("post_clr nit_cnt", int'(nit_cnt_o), 1);
    $display("error after clear -> nit_cnt=%0d", nit_cnt_o);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
